// File: rtl/xm23_pipe_pkg.sv
// Shared types and stall-cause indices for the XM23 pipeline hazard/flow controller.
package xm23_pipe_pkg;

    localparam int unsigned STALL_RAW_E = 0;
    localparam int unsigned STALL_RAW_M = 1;
    localparam int unsigned STALL_RAW_W = 2;
    localparam int unsigned STALL_MEM   = 3;
    localparam int unsigned STALL_SLP   = 4;
    localparam int unsigned STALL_FLUSH = 5;

    localparam int unsigned SHADOW_DEPTH = 3;

    // One in-flight writer: primary destination D and optional second destination S.
    typedef struct packed {
        logic       wr_valid;
        logic [2:0] wr_reg;
        logic       wr2_valid;
        logic [2:0] wr2_reg;
    } shadow_entry_t;

    typedef enum logic {MemIdle, MemWait} mem_state_t;
    typedef enum logic {SlpAwake, SlpSleep} slp_state_t;

    function automatic logic entry_writes(input shadow_entry_t e, input logic [2:0] r);
        return (e.wr_valid && (e.wr_reg == r)) || (e.wr2_valid && (e.wr2_reg == r));
    endfunction

endpackage

// File: rtl/hazard_shadow.sv
// Destination shadow for the E/M/W stages and the RAW compare against the decode stage.
module hazard_shadow
    import xm23_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       shift,
    input  logic       load,
    input  logic       dec_valid,
    input  logic       dec_rd_src,
    input  logic       dec_rd_dst,
    input  logic       dec_wr_dst,
    input  logic       dec_wr_src,
    input  logic [2:0] dec_D,
    input  logic [2:0] dec_S,
    input  logic       dec_rc,
    output logic [2:0] raw_hit
);

    shadow_entry_t [SHADOW_DEPTH-1:0] shadow_q;
    shadow_entry_t                    new_entry;

    always_comb begin
        new_entry = '0;
        if (load) begin
            new_entry = '{wr_valid: dec_wr_dst, wr_reg: dec_D,
                          wr2_valid: dec_wr_src, wr2_reg: dec_S};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
        end else if (shift) begin
            shadow_q[2] <= shadow_q[1];
            shadow_q[1] <= shadow_q[0];
            shadow_q[0] <= new_entry;
        end
    end

    always_comb begin
        raw_hit = '0;
        for (int k = 0; k < SHADOW_DEPTH; k++) begin
            raw_hit[k] = dec_valid &&
                ((dec_rd_src && !dec_rc && entry_writes(shadow_q[k], dec_S)) ||
                 (dec_rd_dst && entry_writes(shadow_q[k], dec_D)));
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// XM23 hazard and flow-control unit: RAW stalls, memory wait freeze, branch flush, sleep hold.
module pipeline_controller
    import xm23_pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dec_valid,
    input  logic       dec_rd_src,
    input  logic       dec_rd_dst,
    input  logic       dec_wr_dst,
    input  logic       dec_wr_src,
    input  logic [2:0] dec_D,
    input  logic [2:0] dec_S,
    input  logic       dec_rc,
    input  logic       branch_fail,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       slp_wb,
    input  logic       wake_i,
    output logic [7:0] stall_o,
    output logic       clear_o,
    output logic       freeze_o,
    output logic       fetch_hold_o,
    output logic       mem_err_o,
    output logic       sleep_o
);

    mem_state_t mem_state_q, mem_state_d;
    slp_state_t slp_state_q, slp_state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;
    logic        branch_pend_q, branch_pend_d;
    logic        branch_now;
    logic        shadow_load;
    logic [2:0]  raw_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_state_q   <= MemIdle;
            slp_state_q   <= SlpAwake;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            flush_cnt_q   <= '0;
            branch_pend_q <= 1'b0;
        end else begin
            mem_state_q   <= mem_state_d;
            slp_state_q   <= slp_state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            flush_cnt_q   <= flush_cnt_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    always_comb begin
        mem_state_d = mem_state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = 1'b0;
        unique case (mem_state_q)
            MemIdle: begin
                if (mem_req && !mem_ready) begin
                    mem_state_d = MemWait;
                    wait_cnt_d  = '0;
                end
            end
            MemWait: begin
                if (mem_ready) begin
                    mem_state_d = MemIdle;
                    wait_cnt_d  = '0;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == 16'(MEM_TIMEOUT - 1))) begin
                    mem_state_d = MemIdle;
                    wait_cnt_d  = '0;
                    mem_err_d   = 1'b1;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: mem_state_d = MemIdle;
        endcase

        slp_state_d = slp_state_q;
        unique case (slp_state_q)
            SlpAwake: if (slp_wb && !wake_i) slp_state_d = SlpSleep;
            SlpSleep: if (wake_i) slp_state_d = SlpAwake;
            default:  slp_state_d = SlpAwake;
        endcase

        // A misprediction seen while frozen is held until the freeze lifts.
        branch_now    = (branch_fail || branch_pend_q) && !freeze_o;
        branch_pend_d = freeze_o && (branch_pend_q || branch_fail);
        flush_cnt_d   = flush_cnt_q;
        if (branch_now) begin
            flush_cnt_d = 8'(FLUSH_CYCLES);
        end else if (!freeze_o && (flush_cnt_q != '0)) begin
            flush_cnt_d = flush_cnt_q - 8'd1;
        end
    end

    always_comb begin
        freeze_o  = (mem_state_q == MemWait);
        sleep_o   = (slp_state_q == SlpSleep);
        clear_o   = (flush_cnt_q != '0);
        mem_err_o = mem_err_q;
        stall_o   = '0;
        stall_o[STALL_RAW_W:STALL_RAW_E] = clear_o ? 3'b000 : raw_hit;
        stall_o[STALL_MEM]   = freeze_o;
        stall_o[STALL_SLP]   = sleep_o;
        stall_o[STALL_FLUSH] = clear_o;
        fetch_hold_o = (|stall_o[STALL_SLP:STALL_RAW_E]) || freeze_o;
    end

    assign shadow_load = dec_valid && !(|stall_o[STALL_SLP:STALL_RAW_E]) && !clear_o &&
                         !branch_now;

    hazard_shadow u_hazard_shadow (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift      (!freeze_o),
        .load       (shadow_load),
        .dec_valid  (dec_valid),
        .dec_rd_src (dec_rd_src),
        .dec_rd_dst (dec_rd_dst),
        .dec_wr_dst (dec_wr_dst),
        .dec_wr_src (dec_wr_src),
        .dec_D      (dec_D),
        .dec_S      (dec_S),
        .dec_rc     (dec_rc),
        .raw_hit    (raw_hit)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Table-driven bench for pipeline_controller plus directed multi-cycle sequences.
module tb_pipeline_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dec_valid, dec_rd_src, dec_rd_dst, dec_wr_dst, dec_wr_src, dec_rc;
    logic [2:0] dec_D, dec_S;
    logic       branch_fail, mem_req, mem_ready, slp_wb, wake_i;
    logic [7:0] stall_o;
    logic       clear_o, freeze_o, fetch_hold_o, mem_err_o, sleep_o;

    int checks = 0;
    int errors = 0;

    pipeline_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dec_valid    (dec_valid),
        .dec_rd_src   (dec_rd_src),
        .dec_rd_dst   (dec_rd_dst),
        .dec_wr_dst   (dec_wr_dst),
        .dec_wr_src   (dec_wr_src),
        .dec_D        (dec_D),
        .dec_S        (dec_S),
        .dec_rc       (dec_rc),
        .branch_fail  (branch_fail),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .slp_wb       (slp_wb),
        .wake_i       (wake_i),
        .stall_o      (stall_o),
        .clear_o      (clear_o),
        .freeze_o     (freeze_o),
        .fetch_hold_o (fetch_hold_o),
        .mem_err_o    (mem_err_o),
        .sleep_o      (sleep_o)
    );

    always #5 clk = ~clk;

    // dec = {valid, rd_src, rd_dst, wr_dst, wr_src}; ctl = {branch_fail, mem_req, mem_ready,
    // slp_wb, wake_i}; expo = {clear, freeze, fetch_hold, mem_err, sleep}
    typedef struct {
        logic [4:0] dec;
        logic [2:0] d;
        logic [2:0] s;
        logic       rc;
        logic [4:0] ctl;
        logic [7:0] stall;
        logic [4:0] expo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] dec, input logic [2:0] d, input logic [2:0] s,
                       input logic rc, input logic [4:0] ctl, input logic [7:0] stall,
                       input logic [4:0] expo);
        vec_t v;
        v.dec = dec; v.d = d; v.s = s; v.rc = rc; v.ctl = ctl; v.stall = stall; v.expo = expo;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] dec, input logic [2:0] d, input logic [2:0] s,
                         input logic rc, input logic [4:0] ctl);
        {dec_valid, dec_rd_src, dec_rd_dst, dec_wr_dst, dec_wr_src} = dec;
        dec_D = d;
        dec_S = s;
        dec_rc = rc;
        {branch_fail, mem_req, mem_ready, slp_wb, wake_i} = ctl;
    endtask

    task automatic check(input string name, input logic [7:0] stall, input logic [4:0] expo);
        logic [4:0] got;
        got = {clear_o, freeze_o, fetch_hold_o, mem_err_o, sleep_o};
        checks++;
        if (stall_o !== stall || got !== expo) begin
            errors++;
            $display("FAIL %s: got stall=%h clr/frz/fh/err/slp=%b, expected stall=%h %b",
                     name, stall_o, got, stall, expo);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int frz_n, err_n, err_at, last_frz, clr_frz, clr_after;

        drive(5'b0, 3'd0, 3'd0, 1'b0, 5'b0);
        #1;
        check("reset_state", 8'h00, 5'b00000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000); // idle after reset
        add(5'b11010, 1, 2, 0, 5'b00000, 8'h00, 5'b00000); // writer of R1
        add(5'b11010, 3, 1, 0, 5'b00000, 8'h01, 5'b00100); // reader of R1: E hit
        add(5'b11010, 3, 1, 0, 5'b00000, 8'h02, 5'b00100); // M hit
        add(5'b11010, 3, 1, 0, 5'b00000, 8'h04, 5'b00100); // W hit
        add(5'b11010, 3, 1, 0, 5'b00000, 8'h00, 5'b00000); // clear, loads writer of R3
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000);
        add(5'b11000, 0, 3, 1, 5'b00000, 8'h00, 5'b00000); // R3 in M but S is a constant
        add(5'b10100, 3, 0, 0, 5'b00000, 8'h04, 5'b00100); // D read of R3 in W
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000);
        add(5'b10001, 0, 5, 0, 5'b00000, 8'h00, 5'b00000); // writes S=R5 only
        add(5'b10100, 5, 0, 0, 5'b00000, 8'h01, 5'b00100); // second-dest hit in E
        add(5'b11000, 0, 5, 0, 5'b00000, 8'h02, 5'b00100);
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000); // no decode, no stall
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000);
        add(5'b00000, 0, 0, 0, 5'b00010, 8'h00, 5'b00000); // SLP retires
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h10, 5'b00101);
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h10, 5'b00101);
        add(5'b00000, 0, 0, 0, 5'b00001, 8'h10, 5'b00101); // wake
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000);
        add(5'b00000, 0, 0, 0, 5'b00011, 8'h00, 5'b00000); // slp with wake
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000); // stays awake
        add(5'b10010, 4, 0, 0, 5'b10000, 8'h00, 5'b00000); // branch_fail, wrong-path writer R4
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h20, 5'b10000);
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h20, 5'b10000);
        add(5'b11000, 0, 4, 0, 5'b00000, 8'h00, 5'b00000); // R4 writer was dropped
        add(5'b00000, 0, 0, 0, 5'b10000, 8'h00, 5'b00000); // branch_fail
        add(5'b00000, 0, 0, 0, 5'b10000, 8'h20, 5'b10000); // second one reloads
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h20, 5'b10000);
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h20, 5'b10000);
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000);
        add(5'b10010, 6, 0, 0, 5'b00000, 8'h00, 5'b00000); // writer of R6
        add(5'b00000, 0, 0, 0, 5'b10000, 8'h00, 5'b00000);
        add(5'b11000, 0, 6, 0, 5'b00000, 8'h20, 5'b10000); // RAW masked by clear
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h20, 5'b10000);
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000);
        add(5'b00000, 0, 0, 0, 5'b01100, 8'h00, 5'b00000); // req with ready: no wait
        add(5'b00000, 0, 0, 0, 5'b00000, 8'h00, 5'b00000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].dec, vecs[i].d, vecs[i].s, vecs[i].rc, vecs[i].ctl);
            #1;
            check($sformatf("vec%0d", i), vecs[i].stall, vecs[i].expo);
        end

        // Memory wait of 3 cycles with a writer of R7 parked in the shadow.
        @(negedge clk); drive(5'b10010, 3'd7, 3'd0, 1'b0, 5'b00000);
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b01000);
        #1; check("memwait_idle", 8'h00, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, (i == 2) ? 5'b00100 : 5'b00000);
            #1; check($sformatf("memwait_frz%0d", i), 8'h08, 5'b01100);
        end
        @(negedge clk); drive(5'b11000, 3'd0, 3'd7, 1'b0, 5'b00000);
        #1; check("memwait_shadow_held", 8'h02, 5'b00100);
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b00000);
        #1; check("memwait_done", 8'h00, 5'b00000);

        // Timeout: mem_ready never arrives.
        frz_n = 0; err_n = 0; err_at = -1; last_frz = -1;
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b01000);
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b00000);
        for (int i = 0; i < 40; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            if (freeze_o) begin frz_n++; last_frz = i; end
            if (mem_err_o) begin err_n++; err_at = i; end
        end
        check_int("timeout_wait_cycles", frz_n, 15);
        check_int("timeout_err_pulses", err_n, 1);
        check_int("timeout_err_cycle", err_at, last_frz + 1);
        check("timeout_idle", 8'h00, 5'b00000);

        // branch_fail during a freeze is deferred until the freeze ends.
        clr_frz = 0; clr_after = 0; frz_n = 0;
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b01000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(5'b00000, 3'd0, 3'd0, 1'b0, {(i == 0), 1'b0, (i == 2), 2'b00});
            #1;
            if (freeze_o) frz_n++;
            if (freeze_o && clear_o) clr_frz++;
            if (!freeze_o && clear_o) clr_after++;
        end
        check_int("frzbr_freeze_cycles", frz_n, 3);
        check_int("frzbr_clear_in_freeze", clr_frz, 0);
        check_int("frzbr_clear_after", clr_after, 2);

        // Asynchronous reset in the middle of WAIT with flush and sleep active.
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b10000);
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b01010);
        @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 1'b0, 5'b00000);
        #1; check("pre_reset", 8'h38, 5'b11101);
        #2; reset_n = 1'b0;
        #1; check("reset_async", 8'h00, 5'b00000);
        @(negedge clk); #1; check("reset_held", 8'h00, 5'b00000);
        @(negedge clk); reset_n = 1'b1;
        #1; check("reset_release", 8'h00, 5'b00000);
        @(negedge clk); #1; check("reset_idle", 8'h00, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Hazard and flow-control unit driving the stall and clear inputs of the XM23 pipeline register bank. It tracks in-flight register writers in a 3-deep destination shadow (execute, memory, writeback) and stalls decode on RAW hazards. It also freezes the pipeline during memory wait states, flushes on branch misprediction and holds the CPU in sleep after SLP retires. It sits between the decoder, memory-access stage and fetch unit.

Parameters:
FLUSH_CYCLES, 2, cycles clear_o stays high after a branch_fail.
MEM_TIMEOUT, 15, max wait cycles on mem_ready before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
dec_valid  in  1  decode stage holds a real instruction
dec_rd_src  in  1  instruction reads register S
dec_rd_dst  in  1  instruction reads register D (ALU two-operand, ST)
dec_wr_dst  in  1  instruction writes register D (incl. LD, SWAP, MOV**)
dec_wr_src  in  1  instruction writes register S (LD/ST pre/post inc/dec, SWAP)
dec_D  in  3  destination register index
dec_S  in  3  source register index
dec_rc  in  1  S field selects a constant, not a register (suppresses S read match)
branch_fail  in  1  execute stage reports misprediction (1-cycle pulse)
mem_req  in  1  memory stage is issuing an access this cycle
mem_ready  in  1  memory completes the access this cycle
slp_wb  in  1  SLP instruction reaches writeback
wake_i  in  1  wake event (interrupt)
stall_o  out  8  per-cause stall vector to the pipeline registers
clear_o  out  1  clear pipeline
freeze_o  out  1  hold all pipeline stages and PC (memory wait)
fetch_hold_o  out  1  fetch must not advance PC
mem_err_o  out  1  1-cycle pulse on memory timeout
sleep_o  out  1  CPU in sleep state

Behaviour:
- Reset (async, reset_n=0): shadow entries invalid, flush counter 0, mem FSM IDLE, sleep FSM AWAKE. All outputs 0.
- Shadow: 3 entries {valid, reg, reg2_valid, reg2}, index 0=E, 1=M, 2=W. Entries shift 0→1→2 each clock unless freeze_o. Entry 0 loads the decode writers only if dec_valid && !stall && !clear_o; otherwise a bubble (valid=0) is loaded.
- RAW stall: stall_o[k] (k=0..2) = dec_valid && shadow[k] holds a writer of a register that decode reads. S reads are ignored when dec_rc=1. Combinational from current state.
- Memory FSM: IDLE→WAIT when mem_req && !mem_ready. In WAIT, freeze_o=1 and stall_o[3]=1.
  - WAIT→IDLE on mem_ready.
  - WAIT→IDLE on timeout: wait counter reaches MEM_TIMEOUT. mem_err_o pulses for 1 cycle and the counter clears.
  - mem_req && mem_ready in IDLE: no wait, no freeze.
- Flush: branch_fail loads the flush counter with FLUSH_CYCLES. clear_o=1 and stall_o[5]=1 while the counter is nonzero; the counter decrements each non-frozen cycle.
  - clear_o is registered, so first assertion is the cycle after branch_fail.
  - branch_fail during a flush reloads the counter.
  - On branch_fail, shadow entry 0 (the wrong-path instruction) is invalidated the same edge.
- Sleep: AWAKE→SLEEP on slp_wb. In SLEEP, sleep_o=1, stall_o[4]=1, fetch_hold_o=1. SLEEP→AWAKE on wake_i. wake_i coincident with slp_wb: remain AWAKE.
- fetch_hold_o = |stall_o[4:0] || freeze_o. stall_o[7:6]=0.
- Priority when simultaneous: reset > branch_fail > mem wait > sleep > RAW.
  - branch_fail during freeze is latched and acted on when the freeze ends.
  - A RAW stall coincident with clear_o is masked (stall_o[2:0]=0).

Decomposition:
- Package xm23_pipe_pkg: stall-cause bit indices (STALL_RAW_E/M/W, STALL_MEM, STALL_SLP, STALL_FLUSH), shadow entry typedef, mem FSM enum {IDLE, WAIT}, sleep enum {AWAKE, SLEEP}.
- One sub-module, hazard_shadow: shadow register plus RAW compare. The FSMs and counters live in the top module.

Test Plan:
- ADD R1,R2 decoded, next cycle MOV R3,R1 (rd_src S=1) → stall_o=8'h01, then 8'h02, then 8'h04, then 8'h00 on the 4th cycle; no stall if dec_rc=1.
- mem_req with mem_ready low for 3 cycles → freeze_o and stall_o[3] high exactly 3 cycles, shadow contents unchanged.
- mem_ready never rises, MEM_TIMEOUT=15 → mem_err_o single pulse after 15 wait cycles, FSM returns to IDLE.
- branch_fail pulse → clear_o high cycles 1–2 after; second branch_fail at cycle 1 extends clear_o through cycle 3; shadow[0] invalid.
- slp_wb → sleep_o, stall_o=8'h10, fetch_hold_o until wake_i; wake_i coincident with slp_wb → no sleep.
- reset_n low mid-WAIT with clear_o active → all outputs 0 immediately (asynchronous), FSMs idle after release.
